// File: rtl/branch_unit_ras.sv
// Registered branch-resolution unit with a circular return-address stack.
// Resolves b/br/conditional/call/ret one cycle after the instruction is presented.
module branch_unit_ras #(
   parameter int unsigned PC_W      = 12,
   parameter int unsigned LABEL_W   = 26,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_in,
   input  logic [5:0]                   opcode,
   input  logic [LABEL_W-1:0]           label,
   input  logic [DATA_W-1:0]            rs_val,
   input  logic                         carry_flag,
   input  logic                         z_flag,
   input  logic                         overflow_flag,
   input  logic                         sign_flag,
   input  logic [PC_W-1:0]              pc,
   input  logic [DATA_W-1:0]            ra_data_old,
   input  logic                         ras_clear,
   output logic                         valid_out,
   output logic                         is_branch,
   output logic [PC_W-1:0]              pc_target,
   output logic                         ra_we,
   output logic [DATA_W-1:0]            ra_data_new,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [5:0] OP_B    = 6'd48;
   localparam logic [5:0] OP_BR   = 6'd49;
   localparam logic [5:0] OP_BZ   = 6'd50;
   localparam logic [5:0] OP_BNZ  = 6'd51;
   localparam logic [5:0] OP_BCY  = 6'd52;
   localparam logic [5:0] OP_BNCY = 6'd53;
   localparam logic [5:0] OP_BS   = 6'd54;
   localparam logic [5:0] OP_BNS  = 6'd55;
   localparam logic [5:0] OP_BV   = 6'd56;
   localparam logic [5:0] OP_BNV  = 6'd57;
   localparam logic [5:0] OP_CALL = 6'd58;
   localparam logic [5:0] OP_RET  = 6'd59;

   logic [PC_W-1:0]   stack_q [RAS_DEPTH];
   logic [PTR_W-1:0]  tp_q, tp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              valid_q, valid_d;
   logic              br_q, br_d;
   logic [PC_W-1:0]   tgt_q, tgt_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rad_q, rad_d;

   logic              push_c;
   logic [PC_W-1:0]   ret_addr_c;
   logic [PC_W-1:0]   lbl_c;
   logic              unused_c;

   assign lbl_c      = label[PC_W-1:0];
   assign ret_addr_c = PC_W'(pc + PC_W'(4));
   assign unused_c   = ^{label, rs_val, ra_data_old};

   // Clear is folded in first so a same-cycle instruction sees an empty stack.
   always_comb begin
      tp_d    = ras_clear ? '0   : tp_q;
      cnt_d   = ras_clear ? '0   : cnt_q;
      ovf_d   = ras_clear ? 1'b0 : ovf_q;
      unf_d   = ras_clear ? 1'b0 : unf_q;
      valid_d = valid_in;
      br_d    = 1'b0;
      tgt_d   = '0;
      we_d    = 1'b0;
      rad_d   = ra_data_old;
      push_c  = 1'b0;
      if (valid_in) begin
         case (opcode)
            OP_B:    begin br_d = 1'b1;           tgt_d = lbl_c; end
            OP_BR:   begin br_d = 1'b1;           tgt_d = rs_val[PC_W-1:0]; end
            OP_BZ:   begin br_d = z_flag;         tgt_d = lbl_c; end
            OP_BNZ:  begin br_d = !z_flag;        tgt_d = lbl_c; end
            OP_BCY:  begin br_d = carry_flag;     tgt_d = lbl_c; end
            OP_BNCY: begin br_d = !carry_flag;    tgt_d = lbl_c; end
            OP_BS:   begin br_d = sign_flag;      tgt_d = lbl_c; end
            OP_BNS:  begin br_d = !sign_flag;     tgt_d = lbl_c; end
            OP_BV:   begin br_d = overflow_flag;  tgt_d = lbl_c; end
            OP_BNV:  begin br_d = !overflow_flag; tgt_d = lbl_c; end
            OP_CALL: begin
               br_d   = 1'b1;
               tgt_d  = lbl_c;
               we_d   = 1'b1;
               rad_d  = DATA_W'(ret_addr_c);
               push_c = 1'b1;
               tp_d   = PTR_W'(tp_d + 1'b1);
               if (cnt_d == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
               else                            cnt_d = CNT_W'(cnt_d + 1'b1);
            end
            OP_RET: begin
               br_d = 1'b1;
               if (cnt_d != '0) begin
                  tgt_d = stack_q[tp_d];
                  tp_d  = PTR_W'(tp_d - 1'b1);
                  cnt_d = CNT_W'(cnt_d - 1'b1);
               end else begin
                  tgt_d = ra_data_old[PC_W-1:0];
                  unf_d = 1'b1;
               end
            end
            default: br_d = 1'b0;
         endcase
      end
      if (!br_d) tgt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         valid_q <= 1'b0;
         br_q    <= 1'b0;
         tgt_q   <= '0;
         we_q    <= 1'b0;
         rad_q   <= '0;
      end else begin
         tp_q    <= tp_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         valid_q <= valid_d;
         br_q    <= br_d;
         tgt_q   <= tgt_d;
         we_q    <= we_d;
         rad_q   <= rad_d;
      end
   end

   // Stack contents are not reset; tp/count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_c) stack_q[tp_d] <= ret_addr_c;
   end

   assign valid_out     = valid_q;
   assign is_branch     = br_q;
   assign pc_target     = tgt_q;
   assign ra_we         = we_q;
   assign ra_data_new   = rad_q;
   assign ras_count     = cnt_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: doc/branch_unit_ras.md
# branch_unit_ras

Registered branch-resolution unit for the KGP-RISC pipeline, parametrised in PC, label and data width. It resolves unconditional, register-indirect and flag-conditional branches, call and return. A return-address stack (RAS) of parametrised depth predicts return targets, so nested calls no longer depend on a single `ra` register. It sits between the decode/flag stage and the PC-update logic. Results are registered with one-cycle latency.

## Interface

Parameters:
- `PC_W`, 12, program-counter width.
- `LABEL_W`, 26, immediate label field width; must be ≥ `PC_W`.
- `DATA_W`, 32, register data width; must be ≥ `PC_W`.
- `RAS_DEPTH`, 8, stack entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  the opcode and operands below are a live instruction this cycle.
- `opcode`  in  6  instruction opcode.
- `label`  in  `LABEL_W`  immediate branch target.
- `rs_val`  in  `DATA_W`  source register value, used for the indirect jump.
- `carry_flag`, `z_flag`, `overflow_flag`, `sign_flag`  in  1 each  ALU flags.
- `pc`  in  `PC_W`  PC of the instruction.
- `ra_data_old`  in  `DATA_W`  current `ra` register value.
- `ras_clear`  in  1  empty the stack; used on pipeline flush or context switch.
- `valid_out`  out  1  outputs below describe the instruction presented one cycle earlier.
- `is_branch`  out  1  take `pc_target`.
- `pc_target`  out  `PC_W`  branch destination; 0 when not taken.
- `ra_we`  out  1  write `ra_data_new` to `ra`.
- `ra_data_new`  out  `DATA_W`  new `ra` value.
- `ras_count`  out  clog2(`RAS_DEPTH`)+1  valid stack entries.
- `ras_overflow`  out  1  sticky: a push overwrote a live entry.
- `ras_underflow`  out  1  sticky: a return found the stack empty.

## Operation

- Opcode decode. L = `label[PC_W-1:0]`.
  - 48 `b`: target L, always taken.
  - 49 `br`: target `rs_val[PC_W-1:0]`, always taken.
  - 50/51 `bz`/`bnz`: taken if `z_flag` = 1 / 0.
  - 52/53 `bcy`/`bncy`: taken if `carry_flag` = 1 / 0.
  - 54/55 `bs`/`bns`: taken if `sign_flag` = 1 / 0.
  - 56/57 `bv`/`bnv`: taken if `overflow_flag` = 1 / 0.
  - Conditional opcodes (50–57) use target L when taken.
  - 58 `call`: target L, always taken. Return address RA = (`pc` + 4) mod 2^`PC_W`, zero-extended to `DATA_W`. RA is pushed on the stack; `ra_we`=1, `ra_data_new`=RA.
  - 59 `ret`: always taken.
    - Stack non-empty: pop; target = popped entry.
    - Stack empty: target = `ra_data_old[PC_W-1:0]`; set `ras_underflow`; count stays 0.
  - Any other opcode: not taken.
- Not-taken result: `is_branch`=0, `pc_target`=0.
- `ra_we`=1 only for a valid call. Otherwise `ra_data_new` = `ra_data_old`, registered.
- Stack structure: circular buffer of `PC_W`-bit entries with top pointer `tp` and `ras_count`.
  - Push: `tp`←`tp`+1 mod `RAS_DEPTH`; write the entry at the new `tp`; `ras_count` saturates at `RAS_DEPTH`.
  - Push when full: overwrites the oldest entry; set `ras_overflow`.
  - Pop: read the entry at `tp`; `tp`←`tp`−1 mod `RAS_DEPTH`; decrement `ras_count`.
- `valid_in`=0: no stack change; `valid_out`, `is_branch`, `ra_we` and `pc_target` register to 0.
- `ras_clear`:
  - Zeroes `tp` and `ras_count`, and clears both sticky flags.
  - Clear with a valid instruction in the same cycle: the clear applies first, then the instruction.
  - Call then leaves count = 1.
  - Return takes the empty path: target from `ra_data_old`, `ras_underflow` = 1 after that edge.
- Flags stay set until `ras_clear` or reset.

## Timing

- Latency: outputs reflect inputs sampled at the previous rising edge. Throughput is one instruction per cycle with no stall.
- Back-to-back call then ret: the ret sees the pushed entry, because the stack updates at the call's edge.
- Asynchronous reset (`rst`=0), immediate, including mid-stream:
  - All outputs go to 0: `valid_out`, `is_branch`, `pc_target`, `ra_we`, `ra_data_new`, `ras_count`, both flags.
  - `tp` goes to 0.
  - Stack contents need not be cleared.
- Release: first capture at the first rising edge with `rst`=1.

## Test plan

- Reset mid-sequence: after 3 calls, assert `rst`=0 between edges → all outputs 0 immediately, `ras_count`=0; a following ret with `ra_data_old`=0x1F0 → target 0x1F0, `ras_underflow`=1.
- Conditionals: `opcode`=50, `label`=0x0ABC, `z_flag`=1 → next cycle `is_branch`=1, `pc_target`=0xABC. Same with `z_flag`=0 → `is_branch`=0, `pc_target`=0. Sweep opcodes 51–57 both polarities.
- Call/return nesting: call at `pc`=0x100, then call at 0x200 → `ra_data_new`=0x204, count 2. Ret → target 0x204; ret → target 0x104; count 0, no flags.
- Wrap and overflow: `RAS_DEPTH`=8; 9 calls at `pc`=0x000,0x010,…,0x080 → `ras_overflow`=1, count 8. 8 rets return 0x084 down to 0x014; a 9th ret uses `ra_data_old`, sets `ras_underflow`.
- PC wrap: call at `pc`=0xFFE → `ra_data_new`=0x00000002, pushed entry 0x002.
- Simultaneous: count 3 plus `ras_clear`=1 with a valid call at 0x040 → count 1, flags 0; the next ret targets 0x044.
